// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encodings, word width
// and the MSB-first byte extraction helper.
package uart_sched_pkg;

    localparam int         WORD_W            = 32;
    localparam logic [7:0] DEFAULT_TERM_BYTE = 8'h0A;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t LOAD    = 3'd1;
    localparam state_t START   = 3'd2;
    localparam state_t WAIT_HI = 3'd3;
    localparam state_t WAIT_LO = 3'd4;
    localparam state_t NEXT    = 3'd5;

    // Byte 0 is the most significant byte of the captured word.
    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] word,
                                             input logic [1:0]        sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request found at or after
// ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    logic [PW-1:0] k_s;
    logic          hit_s;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        k_s       = '0;
        hit_s     = 1'b0;
        for (int i = 0; i < N; i++) begin
            k_s        = PW'((int'(ptr) + i) % N);
            hit_s      = req[k_s] & ~any;
            grant[k_s] = hit_s;
            grant_idx  = hit_s ? k_s : grant_idx;
            any        = any | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_transmitter between N_REQ word producers: captures a word from the
// round-robin winner and feeds it out MSB-first one byte per transmitter frame.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int         N_REQ         = 2,
    parameter int         WORD_BYTES    = 4,
    parameter int         TERM_EN       = 1,
    parameter logic [7:0] TERM_BYTE     = DEFAULT_TERM_BYTE,
    parameter int         BUSY_WAIT_MAX = 16
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ-1:0][WORD_W-1:0]  i_word,
    output logic [N_REQ-1:0]              o_grant,
    output logic                          o_start_uart,
    output logic [7:0]                    o_uart_data,
    input  logic                          i_tx_busy,
    output logic                          o_busy,
    output logic                          o_err
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int IDX_W = $clog2(WORD_BYTES + 2);
    localparam int CNT_W = $clog2(BUSY_WAIT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES + TERM_EN - 1);
    localparam logic [IDX_W-1:0] TERM_IDX = IDX_W'(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_WAIT_MAX - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    state_t              state_r;
    state_t              state_s;
    logic [PTR_W-1:0]    rr_ptr_r;
    logic [IDX_W-1:0]    byte_idx_r;
    logic [CNT_W-1:0]    wait_cnt_r;
    logic [WORD_W-1:0]   shadow_r;

    logic [N_REQ-1:0]    grant_oh_s;
    logic [PTR_W-1:0]    grant_idx_s;
    logic                any_req_s;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_arb (
        .req       (i_req),
        .ptr       (rr_ptr_r),
        .grant     (grant_oh_s),
        .grant_idx (grant_idx_s),
        .any       (any_req_s)
    );

    // Next-state decode of the byte sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD:    state_s = START;
            START:   state_s = WAIT_HI;
            WAIT_HI: begin
                if (i_tx_busy) begin
                    state_s = WAIT_LO;
                end else if (wait_cnt_r == CNT_LAST) begin
                    state_s = NEXT;
                end else begin
                    state_s = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (!i_tx_busy) begin
                    state_s = NEXT;
                end else begin
                    state_s = WAIT_LO;
                end
            end
            NEXT: begin
                if (byte_idx_r == LAST_IDX) begin
                    state_s = IDLE;
                end else begin
                    state_s = LOAD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and the status outputs that mirror it.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_r      <= IDLE;
            o_busy       <= 1'b0;
            o_start_uart <= 1'b0;
        end else begin
            state_r      <= state_s;
            o_busy       <= (state_s != IDLE);
            // Start is issued from START so the data byte is already stable a cycle ahead.
            o_start_uart <= (state_r == START);
        end
    end

    // Capture, pointer rotation and grant pulse on each arbitration win.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            o_grant  <= '0;
            shadow_r <= '0;
            rr_ptr_r <= '0;
        end else if ((state_r == IDLE) && any_req_s) begin
            o_grant  <= grant_oh_s;
            shadow_r <= i_word[grant_idx_s];
            rr_ptr_r <= (grant_idx_s == PTR_LAST) ? '0 : grant_idx_s + PTR_W'(1);
        end else begin
            o_grant  <= '0;
        end
    end

    // Byte index, output data, busy-rise watchdog and sticky error.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            byte_idx_r  <= '0;
            o_uart_data <= 8'h00;
            wait_cnt_r  <= '0;
            o_err       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: byte_idx_r <= '0;
                LOAD: begin
                    if (byte_idx_r == TERM_IDX) begin
                        o_uart_data <= TERM_BYTE;
                    end else begin
                        o_uart_data <= word_byte(shadow_r, byte_idx_r[1:0]);
                    end
                end
                START: wait_cnt_r <= '0;
                WAIT_HI: begin
                    if (!i_tx_busy && (wait_cnt_r == CNT_LAST)) begin
                        o_err <= 1'b1;
                    end else if (!i_tx_busy) begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                NEXT: begin
                    if (byte_idx_r != LAST_IDX) begin
                        byte_idx_r <= byte_idx_r + IDX_W'(1);
                    end else begin
                        byte_idx_r <= byte_idx_r;
                    end
                end
                default: byte_idx_r <= byte_idx_r;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler with a behavioural transmitter model.
module tb_uart_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [1:0]        req_a, req_b;
    logic [1:0][31:0]  word_a, word_b;
    logic [1:0]        grant_a, grant_b;
    logic              start_a, start_b;
    logic [7:0]        data_a, data_b;
    logic              tx_busy_a = 1'b0;
    logic              tx_busy_b = 1'b0;
    logic              sched_busy_a, sched_busy_b;
    logic              err_a, err_b;

    uart_tx_scheduler #(.N_REQ(2), .WORD_BYTES(4), .TERM_EN(1), .TERM_BYTE(8'h0A),
                        .BUSY_WAIT_MAX(16)) dut_a (
        .clk(clk), .i_reset(reset_n), .i_req(req_a), .i_word(word_a), .o_grant(grant_a),
        .o_start_uart(start_a), .o_uart_data(data_a), .i_tx_busy(tx_busy_a),
        .o_busy(sched_busy_a), .o_err(err_a));

    uart_tx_scheduler #(.N_REQ(2), .WORD_BYTES(1), .TERM_EN(0), .TERM_BYTE(8'h0A),
                        .BUSY_WAIT_MAX(16)) dut_b (
        .clk(clk), .i_reset(reset_n), .i_req(req_b), .i_word(word_b), .o_grant(grant_b),
        .o_start_uart(start_b), .o_uart_data(data_b), .i_tx_busy(tx_busy_b),
        .o_busy(sched_busy_b), .o_err(err_b));

    int n_tests = 0;
    int n_fail  = 0;

    int         cyc = 0;
    int         busy_len = 10;
    int         busy_cnt = 0;
    int         starts_a = 0;
    int         last_grant_cyc = -1;
    int         last_drop_cyc  = -1;
    logic [7:0] bytes_q[$];
    logic [1:0] grant_log[$];
    int         gap_grant[$];
    int         gap_busy[$];

    int         starts_b = 0;
    int         busy_cnt_b = 0;
    logic [7:0] last_data_b = 8'h00;

    // Transmitter model and monitor for dut_a; gaps are measured in clock edges.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (grant_a != 2'b00) begin
            grant_log.push_back(grant_a);
            last_grant_cyc = cyc;
        end
        if (start_a) begin
            bytes_q.push_back(data_a);
            starts_a++;
            if (last_grant_cyc >= 0) begin
                gap_grant.push_back(cyc - last_grant_cyc);
            end else if (last_drop_cyc >= 0) begin
                // dut_a first sees the low busy on the edge after the model drops it
                gap_busy.push_back(cyc - (last_drop_cyc + 1));
            end
            last_grant_cyc = -1;
            last_drop_cyc  = -1;
            if (busy_len > 0) begin
                tx_busy_a = 1'b1;
                busy_cnt  = busy_len;
            end
        end else if (tx_busy_a) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy_a     = 1'b0;
                last_drop_cyc = cyc;
            end
        end
    end

    // Transmitter model and monitor for dut_b.
    always @(posedge clk) begin
        #1;
        if (start_b) begin
            starts_b++;
            last_data_b = data_b;
            tx_busy_b   = 1'b1;
            busy_cnt_b  = 3;
        end else if (tx_busy_b) begin
            busy_cnt_b--;
            if (busy_cnt_b == 0) tx_busy_b = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        bytes_q.delete();
        grant_log.delete();
        gap_grant.delete();
        gap_busy.delete();
        starts_a       = 0;
        last_grant_cyc = -1;
        last_drop_cyc  = -1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while ((grant_log.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check_eq("grant_wait", 64'(grant_log.size() >= n), 64'd1);
    endtask

    task automatic wait_word(input int n, input int budget);
        int k = 0;
        while (!((starts_a >= n) && !sched_busy_a && !tx_busy_a) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check_eq("word_wait", 64'(k < budget), 64'd1);
    endtask

    task automatic check_seq(input string tag, input logic [79:0] exp, input int n);
        logic [63:0] got;
        for (int i = 0; i < n; i++) begin
            got = (i < bytes_q.size()) ? 64'(bytes_q[i]) : 64'hBAD;
            check_eq($sformatf("%s_b%0d", tag, i), got, 64'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    task automatic send_one(input logic [31:0] w);
        clear_mon();
        word_a[0] = w;
        req_a     = 2'b01;
        wait_grants(1, 20);
        req_a     = 2'b00;
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        req_a   = 2'b00;
        req_b   = 2'b00;
        word_a  = '0;
        word_b  = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_a", {grant_a, start_a, data_a, sched_busy_a, err_a}, 64'd0);
        check_eq("reset_b", {grant_b, start_b, data_b, sched_busy_b, err_b}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single word with terminator, plus grant/busy-to-start timing.
        send_one(32'hDEADBEEF);
        wait_word(5, 300);
        check_eq("single_grant", 64'(grant_log[0]), 64'h1);
        check_eq("single_starts", 64'(starts_a), 64'd5);
        check_seq("single", 80'h0000_0000_DEADBEEF_0A, 5);
        check_eq("single_idle", 64'(sched_busy_a), 64'd0);
        check_eq("single_err", 64'(err_a), 64'd0);
        check_eq("gap_grant_start", 64'(gap_grant[0]), 64'd2);
        check_eq("gap_busy_start0", 64'(gap_busy[0]), 64'd3);
        check_eq("gap_busy_start3", 64'(gap_busy[3]), 64'd3);

        // Contention: both requesters held, grants must alternate from req0.
        apply_reset();
        clear_mon();
        word_a[0] = 32'h11223344;
        word_a[1] = 32'h55667788;
        req_a     = 2'b11;
        wait_grants(3, 400);
        req_a     = 2'b00;
        wait_word(15, 300);
        check_eq("cont_g0", 64'(grant_log[0]), 64'h1);
        check_eq("cont_g1", 64'(grant_log[1]), 64'h2);
        check_eq("cont_g2", 64'(grant_log[2]), 64'h1);
        check_eq("cont_starts", 64'(starts_a), 64'd15);
        check_seq("cont", 80'h11223344_0A_55667788_0A, 10);

        // Reset during WAIT_LO of the third byte, then a fresh word from byte 0.
        send_one(32'hDEADBEEF);
        k = 0;
        while (!((starts_a >= 3) && tx_busy_a) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        check_eq("midword_reach", 64'(k < 200), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("midword_reset", {grant_a, start_a, data_a, sched_busy_a, err_a}, 64'd0);
        k = 0;
        while (tx_busy_a && (k < 40)) begin
            @(negedge clk);
            k++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_reset_quiet", 64'(sched_busy_a), 64'd0);
        send_one(32'hDEADBEEF);
        wait_word(5, 300);
        check_eq("rst_grant", 64'(grant_log[0]), 64'h1);
        check_eq("rst_starts", 64'(starts_a), 64'd5);
        check_seq("rst", 80'h0000_0000_DEADBEEF_0A, 5);

        // Busy never rises: error after 16 WAIT_HI cycles, word still completes.
        busy_len = 0;
        send_one(32'h01020304);
        k = 0;
        while ((starts_a < 1) && (k < 20)) begin
            @(negedge clk);
            k++;
        end
        check_eq("to_first_start", 64'(starts_a), 64'd1);
        repeat (15) @(negedge clk);
        check_eq("to_err_early", 64'(err_a), 64'd0);
        @(negedge clk);
        check_eq("to_err_set", 64'(err_a), 64'd1);
        wait_word(5, 300);
        check_eq("to_starts", 64'(starts_a), 64'd5);
        check_seq("to", 80'h0000_0000_01020304_0A, 5);
        check_eq("to_err_sticky", 64'(err_a), 64'd1);
        busy_len = 10;

        // One-byte variant without terminator.
        word_b[0] = 32'hA5000000;
        word_b[1] = 32'h5A5A5A5A;
        req_b     = 2'b01;
        k = 0;
        while ((grant_b == 2'b00) && (k < 20)) begin
            @(negedge clk);
            k++;
        end
        check_eq("var_grant", 64'(grant_b), 64'h1);
        req_b = 2'b00;
        repeat (30) @(negedge clk);
        check_eq("var_starts", 64'(starts_b), 64'd1);
        check_eq("var_data", 64'(last_data_b), 64'hA5);
        check_eq("var_idle", 64'(sched_busy_b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
